rot_sequencer: RTL

- Command-level controller that sits directly upstream of the 8-bit rotating shift register (part1) and drives its ploadn, rright and datain inputs.
- Accepts one command: data, rotate amount, direction. It loads the register, runs it for exactly the requested number of rotate cycles, then captures the register output as the result.
- Turns the free-running rotator into a one-shot "rotate by N" unit with a start/busy/done handshake.

---
 rtl/rot_sequencer_pkg.sv | 17 +
 rtl/part1.sv | 31 +++
 rtl/rot_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/rot_sequencer_pkg.sv
// Shared definitions for the rotate-by-N sequencer and its shift register.
package rot_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_AW    = 3;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_CAPT  = 2'd3;

endpackage

// File: rtl/part1.sv
// Free-running rotating shift register: parallel load when ploadn=0, otherwise rotates every edge.
module part1
  import rot_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ploadn,
  input  logic             rright,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] qout
);

  logic [WIDTH-1:0] qout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qout_q <= '0;
    end else if (!ploadn) begin
      qout_q <= datain;
    end else if (rright == DIR_RIGHT) begin
      qout_q <= {qout_q[0], qout_q[WIDTH-1:1]};
    end else begin
      qout_q <= {qout_q[WIDTH-2:0], qout_q[WIDTH-1]};
    end
  end

  assign qout = qout_q;

endmodule

// File: rtl/rot_sequencer.sv
// One-shot "rotate by N" controller wrapped around a free-running rotator.
// Loads the register, lets it rotate exactly `amount` edges, then samples qout.
module rot_sequencer
  import rot_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    amount,
  input  logic             dir,
  input  logic [WIDTH-1:0] qout,
  output logic             ploadn,
  output logic             rright,
  output logic [WIDTH-1:0] datain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ploadn_q, ploadn_d;
  logic             rright_q, rright_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ploadn_q <= 1'b1;
      rright_q <= 1'b0;
      datain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ploadn_q <= ploadn_d;
      rright_q <= rright_d;
      datain_q <= datain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // ploadn is registered, so it is driven low on the accepting edge to be low during LOAD
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ploadn_d = 1'b1;
    rright_d = rright_q;
    datain_d = datain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          datain_d = din;
          rright_d = dir;
          cnt_d    = amount;
          busy_d   = 1'b1;
          ploadn_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_CAPT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        result_d = qout;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ploadn = ploadn_q;
  assign rright = rright_q;
  assign datain = datain_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
